// File: rtl/led_fade_pwm_pkg.sv
// Shared defaults for the LED fade/PWM stage: channel count, brightness width, decay divider.
package led_fade_pwm_pkg;
  localparam int N_LED_DEF     = 8;
  localparam int BR_W_DEF      = 4;
  localparam int DECAY_DIV_DEF = 1024;

  // Full-scale brightness for a given level width.
  function automatic int br_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern-in / LED-out bundle between the walking-LED shifter and the fade stage.
interface led_fade_pwm_if #(
  parameter int N_LED = 8
);
  logic [N_LED-1:0] pat_in;
  logic             pat_valid;
  logic             fade_en;
  logic [N_LED-1:0] led_out;
  logic             busy;

  modport master (output pat_in, pat_valid, fade_en, input led_out, busy);
  modport slave  (input pat_in, pat_valid, fade_en, output led_out, busy);
endinterface

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: brightness level register with reload/clear/decay priority and PWM compare.
module led_fade_pwm_channel
  import led_fade_pwm_pkg::*;
#(
  parameter int BR_W = BR_W_DEF
) (
  input  logic            clock,
  input  logic            sys_rst_n,
  input  logic [BR_W-1:0] pwm_cnt,
  input  logic            decay_tick,
  input  logic            pat_bit,
  input  logic            pat_valid,
  input  logic            fade_en,
  output logic            drive,
  output logic            nonzero
);
  localparam logic [BR_W-1:0] BR_MAX = BR_W'(br_max(BR_W));

  logic [BR_W-1:0] level;

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level <= '0;
      drive <= 1'b0;
    end else begin
      // Compare uses the pre-update level, so a reload shows on the pin one edge later.
      drive <= (level > pwm_cnt);
      if (pat_valid && pat_bit)
        level <= BR_MAX;
      else if (!fade_en && (pat_valid || level != BR_MAX))
        level <= '0;
      else if (fade_en && decay_tick && level != '0)
        level <= level - 1'b1;
    end
  end

  assign nonzero = |level;
endmodule

// File: rtl/led_fade_pwm.sv
// LED fade stage top: shared PWM and decay timebases, per-channel level array, busy reduce.
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int N_LED     = N_LED_DEF,
  parameter int BR_W      = BR_W_DEF,
  parameter int DECAY_DIV = DECAY_DIV_DEF
) (
  input logic           clock,
  input logic           sys_rst_n,
  led_fade_pwm_if.slave bus
);
  localparam int              DC_W     = $clog2(DECAY_DIV);
  localparam logic [BR_W-1:0] PWM_LAST = BR_W'(br_max(BR_W) - 1);
  localparam logic [DC_W-1:0] DC_LAST  = DC_W'(DECAY_DIV - 1);

  logic [BR_W-1:0]  pwm_cnt;
  logic [DC_W-1:0]  decay_cnt;
  logic             decay_tick;
  logic [N_LED-1:0] drive;
  logic [N_LED-1:0] nonzero;

  // Period is BR_MAX cycles so level BR_MAX stays on and level 0 stays off.
  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt   <= '0;
      decay_cnt <= '0;
    end else begin
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      decay_cnt <= (decay_cnt == DC_LAST) ? '0 : decay_cnt + 1'b1;
    end
  end

  assign decay_tick = (decay_cnt == DC_LAST);

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    led_fade_pwm_channel #(.BR_W(BR_W)) u_ch (
      .clock      (clock),
      .sys_rst_n  (sys_rst_n),
      .pwm_cnt    (pwm_cnt),
      .decay_tick (decay_tick),
      .pat_bit    (bus.pat_in[g]),
      .pat_valid  (bus.pat_valid),
      .fade_en    (bus.fade_en),
      .drive      (drive[g]),
      .nonzero    (nonzero[g])
    );
  end

  assign bus.led_out = drive;
  assign bus.busy    = |nonzero;
endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with a short decay divider (4) so fades complete quickly.
module tb_led_fade_pwm;
  logic clock = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   edges;
  int   bad;

  always #5 clock = ~clock;

  led_fade_pwm_if #(.N_LED(8)) bus ();

  led_fade_pwm #(.N_LED(8), .BR_W(4), .DECAY_DIV(4)) dut (
    .clock     (clock),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  logic [3:0] lv [8];
  for (genvar g = 0; g < 8; g++) begin : g_peek
    assign lv[g] = dut.g_ch[g].u_ch.level;
  end

  // Edges since reset release; the decay counter before an edge equals edges % 4.
  always @(posedge clock or negedge sys_rst_n)
    if (!sys_rst_n) edges <= 0;
    else            edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Next posedge will see decay_cnt == ph.
  task automatic align(input int ph);
    while (edges % 4 != ph) @(negedge clock);
  endtask

  task automatic pulse(input logic [7:0] p);
    bus.pat_in    = p;
    bus.pat_valid = 1'b1;
    @(negedge clock);
    bus.pat_valid = 1'b0;
    bus.pat_in    = 8'h00;
  endtask

  initial begin
    bus.pat_in    = 8'h00;
    bus.pat_valid = 1'b0;
    bus.fade_en   = 1'b0;

    // 1: reset and idle
    step(5);
    sys_rst_n = 1'b1;
    step(1);
    chk("rst_led", 32'(bus.led_out), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    step(100);
    chk("idle_led", 32'(bus.led_out), 32'h00);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // 2: load ch0, then ch1; both fade 15 -> 0 over 15 ticks
    bus.fade_en = 1'b1;
    align(0);
    pulse(8'h01);
    chk("load_lv0", 32'(lv[0]), 32'd15);
    chk("load_busy", 32'(bus.busy), 32'h1);
    pulse(8'h02);
    chk("hold_lv0", 32'(lv[0]), 32'd15);
    chk("load_lv1", 32'(lv[1]), 32'd15);
    chk("full_led0", 32'(bus.led_out[0]), 32'h1);
    for (int j = 1; j <= 15; j++) begin
      step(j == 1 ? 2 : 4);
      chk($sformatf("fade_lv0_%0d", j), 32'(lv[0]), 32'(15 - j));
      if (j == 7) chk("fade_lv1_7", 32'(lv[1]), 32'd8);
      if (j == 14) chk("busy_tail", 32'(bus.busy), 32'h1);
    end
    chk("fade_done_busy", 32'(bus.busy), 32'h0);
    step(1);
    chk("fade_done_led", 32'(bus.led_out), 32'h00);

    // 3: reload coincident with a decay tick
    align(0);
    pulse(8'hC0);
    step(39);
    chk("pre_lv7", 32'(lv[7]), 32'd5);
    chk("pre_lv6", 32'(lv[6]), 32'd5);
    align(3);
    pulse(8'h80);
    chk("tick_lv7", 32'(lv[7]), 32'd15);
    chk("tick_lv6", 32'(lv[6]), 32'd4);

    // 4: hard on/off mode
    bus.fade_en = 1'b0;
    step(1);
    chk("off_lv6", 32'(lv[6]), 32'd0);
    chk("off_lv7_hold", 32'(lv[7]), 32'd15);
    pulse(8'h10);
    chk("off_lv4", 32'(lv[4]), 32'd15);
    chk("off_lv7_clr", 32'(lv[7]), 32'd0);
    step(1);
    chk("off_led4_on", 32'(bus.led_out[4]), 32'h1);
    pulse(8'h20);
    chk("off_led4_lag", 32'(bus.led_out[4]), 32'h1);
    step(1);
    chk("off_led4_fall", 32'(bus.led_out[4]), 32'h0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.led_out[5] !== 1'b1 || bus.led_out[4] !== 1'b0) bad++;
      step(1);
    end
    chk("off_led5_full", 32'(bad), 32'd0);

    // 5: levels 15/9/3, fade_en drops, then async reset mid-period
    bus.fade_en = 1'b1;
    align(0);
    pulse(8'h04);
    step(23);
    pulse(8'h02);
    step(23);
    pulse(8'h01);
    chk("mid_lv0", 32'(lv[0]), 32'd15);
    chk("mid_lv1", 32'(lv[1]), 32'd9);
    chk("mid_lv2", 32'(lv[2]), 32'd3);
    bus.fade_en = 1'b0;
    step(1);
    chk("drop_lv0", 32'(lv[0]), 32'd15);
    chk("drop_lv1", 32'(lv[1]), 32'd0);
    chk("drop_lv2", 32'(lv[2]), 32'd0);
    chk("drop_led0", 32'(bus.led_out[0]), 32'h1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_led", 32'(bus.led_out), 32'h00);
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_lv0", 32'(lv[0]), 32'd0);
    step(2);
    sys_rst_n = 1'b1;

    // 6: decay saturates at zero
    bus.fade_en = 1'b1;
    align(0);
    pulse(8'h01);
    step(55);
    chk("sat_lv1", 32'(lv[0]), 32'd1);
    step(12);
    chk("sat_lv0", 32'(lv[0]), 32'd0);
    chk("sat_busy", 32'(bus.busy), 32'h0);
    chk("sat_led", 32'(bus.led_out), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
